// File: rtl/kv_table_writer.sv
// Key/data lookup table maintained from a command stream (write, delete, clear).
// Each command takes four cycles: accept, search, commit, respond.
module kv_table_writer #(
    parameter int N_KEY    = 4,
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 8,
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN,
    localparam int SLOT_W   = $clog2(N_KEY),
    localparam int CNT_W    = $clog2(N_KEY + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [KEY_LEN-1:0]        cmd_key,
    input  logic [DATA_LEN-1:0]       cmd_data,
    output logic                      resp_valid,
    output logic [2:0]                resp_status,
    output logic [SLOT_W-1:0]         resp_slot,
    output logic [N_KEY*PAIR_LEN-1:0] lut,
    output logic [N_KEY-1:0]          lut_valid,
    output logic [CNT_W-1:0]          count
);

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_DELETE = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    localparam logic [2:0] ST_INSERT   = 3'd0;
    localparam logic [2:0] ST_UPDATE   = 3'd1;
    localparam logic [2:0] ST_DELETE   = 3'd2;
    localparam logic [2:0] ST_CLEAR    = 3'd3;
    localparam logic [2:0] ST_ERR_FULL = 3'd4;
    localparam logic [2:0] ST_ERR_MISS = 3'd5;
    localparam logic [2:0] ST_NOP      = 3'd6;

    typedef enum logic [1:0] {IDLE, SEARCH, COMMIT, RESP} state_t;

    state_t state, state_next;

    logic [1:0]          op_q;
    logic [KEY_LEN-1:0]  key_q;
    logic [DATA_LEN-1:0] data_q;

    logic [KEY_LEN-1:0]  slot_key  [N_KEY];
    logic [DATA_LEN-1:0] slot_data [N_KEY];
    logic [N_KEY-1:0]    valid;
    logic [CNT_W-1:0]    count_q;
    logic [2:0]          status_q;
    logic [SLOT_W-1:0]   slot_q;

    logic              hit_c, free_any_c;
    logic [SLOT_W-1:0] hit_idx_c, free_idx_c;
    logic              hit_q, free_any_q;
    logic [SLOT_W-1:0] hit_idx_q, free_idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = SEARCH;
            SEARCH:  state_next = COMMIT;
            COMMIT:  state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_valid) begin
            op_q   <= cmd_op;
            key_q  <= cmd_key;
            data_q <= cmd_data;
        end
    end

    // Descending scan so the lowest-index free slot wins; keys are unique so at most one hit.
    always_comb begin
        hit_c      = 1'b0;
        hit_idx_c  = '0;
        free_any_c = 1'b0;
        free_idx_c = '0;
        for (int i = N_KEY - 1; i >= 0; i--) begin
            if (valid[i] && slot_key[i] == key_q) begin
                hit_c     = 1'b1;
                hit_idx_c = SLOT_W'(i);
            end
            if (!valid[i]) begin
                free_any_c = 1'b1;
                free_idx_c = SLOT_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == SEARCH) begin
            hit_q      <= hit_c;
            hit_idx_q  <= hit_idx_c;
            free_any_q <= free_any_c;
            free_idx_q <= free_idx_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid    <= '0;
            count_q  <= '0;
            status_q <= '0;
            slot_q   <= '0;
            for (int i = 0; i < N_KEY; i++) begin
                slot_key[i]  <= '0;
                slot_data[i] <= '0;
            end
        end else if (state == COMMIT) begin
            slot_q <= '0;
            case (op_q)
                OP_WRITE: begin
                    if (hit_q) begin
                        slot_data[hit_idx_q] <= data_q;
                        status_q             <= ST_UPDATE;
                        slot_q               <= hit_idx_q;
                    end else if (free_any_q) begin
                        slot_key[free_idx_q]  <= key_q;
                        slot_data[free_idx_q] <= data_q;
                        valid[free_idx_q]     <= 1'b1;
                        count_q               <= count_q + CNT_W'(1);
                        status_q              <= ST_INSERT;
                        slot_q                <= free_idx_q;
                    end else begin
                        status_q <= ST_ERR_FULL;
                    end
                end
                OP_DELETE: begin
                    if (hit_q) begin
                        slot_key[hit_idx_q]  <= '0;
                        slot_data[hit_idx_q] <= '0;
                        valid[hit_idx_q]     <= 1'b0;
                        count_q              <= count_q - CNT_W'(1);
                        status_q             <= ST_DELETE;
                        slot_q               <= hit_idx_q;
                    end else begin
                        status_q <= ST_ERR_MISS;
                    end
                end
                OP_CLEAR: begin
                    valid    <= '0;
                    count_q  <= '0;
                    status_q <= ST_CLEAR;
                    for (int i = 0; i < N_KEY; i++) begin
                        slot_key[i]  <= '0;
                        slot_data[i] <= '0;
                    end
                end
                default: status_q <= ST_NOP;
            endcase
        end
    end

    // Freed slots are zeroed on delete/clear, so the bus is a plain view of the registers.
    always_comb begin
        lut = '0;
        for (int i = 0; i < N_KEY; i++) begin
            lut[PAIR_LEN*i +: PAIR_LEN] = {slot_key[i], slot_data[i]};
        end
    end

    assign lut_valid   = valid;
    assign count       = count_q;
    assign resp_status = status_q;
    assign resp_slot   = slot_q;

endmodule

// File: tb/tb_kv_table_writer.sv
// Directed table-driven bench for kv_table_writer, plus a reset-during-commit sequence.
module tb_kv_table_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_key;
    logic [7:0]  cmd_data;
    logic        resp_valid;
    logic [2:0]  resp_status;
    logic [1:0]  resp_slot;
    logic [47:0] lut;
    logic [3:0]  lut_valid;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [47:0] prev_lut;

    kv_table_writer #(.N_KEY(4), .KEY_LEN(4), .DATA_LEN(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_key(cmd_key), .cmd_data(cmd_data),
        .resp_valid(resp_valid), .resp_status(resp_status), .resp_slot(resp_slot),
        .lut(lut), .lut_valid(lut_valid), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  key;
        logic [7:0]  data;
        logic [2:0]  status;
        logic [1:0]  slot;
        logic [3:0]  valid;
        logic [2:0]  cnt;
        logic [47:0] lut;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        int lat;
        cmd_op = v.op; cmd_key = v.key; cmd_data = v.data; cmd_valid = 1'b1;
        chk($sformatf("ready_idle[%0d]", idx), 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        // scramble inputs after acceptance; the DUT must use the captured copy
        cmd_valid = 1'b0; cmd_op = v.op ^ 2'b01; cmd_key = ~v.key; cmd_data = ~v.data;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            chk($sformatf("ready_busy[%0d]", idx), 64'(cmd_ready), 64'd0);
            chk($sformatf("lut_stable[%0d]", idx), 64'(lut), 64'(prev_lut));
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency[%0d]", idx), 64'(lat), 64'd3);
        chk($sformatf("status[%0d]", idx), 64'(resp_status), 64'(v.status));
        chk($sformatf("slot[%0d]", idx), 64'(resp_slot), 64'(v.slot));
        chk($sformatf("lut[%0d]", idx), 64'(lut), 64'(v.lut));
        chk($sformatf("lut_valid[%0d]", idx), 64'(lut_valid), 64'(v.valid));
        chk($sformatf("count[%0d]", idx), 64'(count), 64'(v.cnt));
        chk($sformatf("ready_resp[%0d]", idx), 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        chk($sformatf("resp_pulse[%0d]", idx), 64'(resp_valid), 64'd0);
        chk($sformatf("ready_after[%0d]", idx), 64'(cmd_ready), 64'd1);
        chk($sformatf("status_hold[%0d]", idx), 64'(resp_status), 64'(v.status));
        prev_lut = v.lut;
    endtask

    initial begin
        // op, key, data, status, slot, valid, count, lut
        vecs[0]  = '{2'b00, 4'h3, 8'hA5, 3'd0, 2'd0, 4'b0001, 3'd1, 48'h000_000_000_3A5};
        vecs[1]  = '{2'b00, 4'h3, 8'h5A, 3'd1, 2'd0, 4'b0001, 3'd1, 48'h000_000_000_35A};
        vecs[2]  = '{2'b00, 4'h5, 8'h11, 3'd0, 2'd1, 4'b0011, 3'd2, 48'h000_000_511_35A};
        vecs[3]  = '{2'b00, 4'hA, 8'h22, 3'd0, 2'd2, 4'b0111, 3'd3, 48'h000_A22_511_35A};
        vecs[4]  = '{2'b00, 4'h8, 8'h33, 3'd0, 2'd3, 4'b1111, 3'd4, 48'h833_A22_511_35A};
        vecs[5]  = '{2'b00, 4'h9, 8'h44, 3'd4, 2'd0, 4'b1111, 3'd4, 48'h833_A22_511_35A};
        vecs[6]  = '{2'b01, 4'h7, 8'h00, 3'd5, 2'd0, 4'b1111, 3'd4, 48'h833_A22_511_35A};
        vecs[7]  = '{2'b01, 4'h5, 8'h00, 3'd2, 2'd1, 4'b1101, 3'd3, 48'h833_A22_000_35A};
        vecs[8]  = '{2'b00, 4'h6, 8'h66, 3'd0, 2'd1, 4'b1111, 3'd4, 48'h833_A22_666_35A};
        vecs[9]  = '{2'b01, 4'h8, 8'h00, 3'd2, 2'd3, 4'b0111, 3'd3, 48'h000_A22_666_35A};
        vecs[10] = '{2'b11, 4'h3, 8'h77, 3'd6, 2'd0, 4'b0111, 3'd3, 48'h000_A22_666_35A};
        vecs[11] = '{2'b10, 4'h0, 8'h00, 3'd3, 2'd0, 4'b0000, 3'd0, 48'h000_000_000_000};
        vecs[12] = '{2'b01, 4'h3, 8'h00, 3'd5, 2'd0, 4'b0000, 3'd0, 48'h000_000_000_000};
        vecs[13] = '{2'b00, 4'h0, 8'h00, 3'd0, 2'd0, 4'b0001, 3'd1, 48'h000_000_000_000};
        vecs[14] = '{2'b00, 4'h0, 8'hFF, 3'd1, 2'd0, 4'b0001, 3'd1, 48'h000_000_000_0FF};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; cmd_data = '0;
        prev_lut = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lut", 64'(lut), 64'd0);
        chk("rst_lut_valid", 64'(lut_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_status", 64'(resp_status), 64'd0);
        chk("rst_slot", 64'(resp_slot), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) run_cmd(vecs[i], i);

        // Reset asserted while an insert is in its COMMIT cycle
        cmd_op = 2'b00; cmd_key = 4'h4; cmd_data = 8'h44; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_lut", 64'(lut), 64'd0);
        chk("midrst_lut_valid", 64'(lut_valid), 64'd0);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_status", 64'(resp_status), 64'd0);
        chk("midrst_slot", 64'(resp_slot), 64'd0);
        chk("midrst_ready", 64'(cmd_ready), 64'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_resp", 64'(resp_valid), 64'd0);
            chk("midrst_no_write", 64'(lut_valid), 64'd0);
        end
        prev_lut = '0;
        run_cmd('{2'b00, 4'h4, 8'h44, 3'd0, 2'd0, 4'b0001, 3'd1, 48'h000_000_000_444}, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
